// File: rtl/cam_pkg.sv
// Shared types and default geometry for the camera frame-buffer write path.
package cam_pkg;
  localparam int CAM_FB_W      = 240;
  localparam int CAM_FB_H      = 320;
  localparam int CAM_FB_ADDR_W = 17;

  typedef logic [15:0] rgb565_t;

  typedef enum logic {SYNC, ACTIVE} cam_wr_state_t;
endpackage

// File: rtl/cam_fb_writer_if.sv
// Camera byte stream in, frame-buffer write port out; master is the writer, slave the environment.
interface cam_fb_writer_if #(
  parameter int ADDR_W = cam_pkg::CAM_FB_ADDR_W
);
  logic              cam_vsync_in;
  logic              cam_href_in;
  logic              cam_byte_vld_in;
  logic [7:0]        cam_byte_in;
  logic [ADDR_W-1:0] fb_addr_out;
  logic [15:0]       fb_data_out;
  logic              fb_we_out;

  modport master (
    input  cam_vsync_in, cam_href_in, cam_byte_vld_in, cam_byte_in,
    output fb_addr_out, fb_data_out, fb_we_out
  );

  modport slave (
    output cam_vsync_in, cam_href_in, cam_byte_vld_in, cam_byte_in,
    input  fb_addr_out, fb_data_out, fb_we_out
  );
endinterface

// File: rtl/cam_byte_pack.sv
// Pairs camera bytes into RGB565 pixels; the high byte arrives first.
module cam_byte_pack
  import cam_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       clr,
  input  logic       byte_vld,
  input  logic [7:0] cam_byte,
  output logic       pix_vld,
  output rgb565_t    pix,
  output logic       half
);
  logic       phase;
  logic [7:0] hi;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase <= 1'b0;
      hi    <= '0;
    end else if (clr) begin
      phase <= 1'b0;
    end else if (byte_vld) begin
      if (!phase) hi <= cam_byte;
      phase <= ~phase;
    end
  end

  // Pixel is formed combinationally so the top can register the write one clock later.
  assign pix_vld = byte_vld & phase & ~clr;
  assign pix     = {hi, cam_byte};
  assign half    = phase;
endmodule

// File: rtl/cam_fb_writer.sv
// Camera-to-frame-buffer writer: vsync/href framing, RGB565 packing, windowed linear addressing.
// Optional build macro CAM_FB_FREEZE_EN adds freeze_in to skip writing whole frames.
//
// state  | meaning
// SYNC   | vertical blanking or waiting for first vsync fall; bytes ignored
// ACTIVE | capturing a frame; href-qualified bytes become pixels
module cam_fb_writer
  import cam_pkg::*;
#(
  parameter int FB_W   = CAM_FB_W,
  parameter int FB_H   = CAM_FB_H,
  parameter int ADDR_W = CAM_FB_ADDR_W
) (
  input  logic clk_in,
  input  logic rst_n_in,
`ifdef CAM_FB_FREEZE_EN
  input  logic freeze_in,
`endif
  cam_fb_writer_if.master bus,
  output logic frame_done_out,
  output logic err_out
);
  localparam logic [10:0]       COL_LIM  = 11'(FB_W);
  localparam logic [10:0]       ROW_LIM  = 11'(FB_H);
  localparam logic [10:0]       CNT_MAX  = 11'h7FF;
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

  cam_wr_state_t     state;
  logic              vsync_q, href_q;
  logic [10:0]       col, row;
  logic [ADDR_W-1:0] row_base;
  logic              active, vsync_fall, vsync_rise, href_fall, byte_acc;
  logic              pix_vld, half, frozen;
  rgb565_t           pix;

  assign active     = (state == ACTIVE);
  assign vsync_fall = vsync_q & ~bus.cam_vsync_in;
  assign vsync_rise = ~vsync_q & bus.cam_vsync_in;
  assign href_fall  = active & href_q & ~bus.cam_href_in;
  assign byte_acc   = active & ~vsync_fall & bus.cam_href_in & bus.cam_byte_vld_in;

  cam_byte_pack u_pack (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clr      (vsync_fall | href_fall),
    .byte_vld (byte_acc),
    .cam_byte (bus.cam_byte_in),
    .pix_vld  (pix_vld),
    .pix      (pix),
    .half     (half)
  );

`ifdef CAM_FB_FREEZE_EN
  // Latched once per frame so a mid-frame change can never tear the stored image.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)       frozen <= 1'b0;
    else if (vsync_fall) frozen <= freeze_in;
  end
`else
  assign frozen = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= SYNC;
      vsync_q         <= 1'b0;
      href_q          <= 1'b0;
      col             <= '0;
      row             <= '0;
      row_base        <= '0;
      bus.fb_we_out   <= 1'b0;
      bus.fb_addr_out <= '0;
      bus.fb_data_out <= '0;
      frame_done_out  <= 1'b0;
      err_out         <= 1'b0;
    end else begin
      vsync_q        <= bus.cam_vsync_in;
      href_q         <= bus.cam_href_in;
      bus.fb_we_out  <= 1'b0;
      frame_done_out <= 1'b0;
      if (vsync_fall) begin
        state    <= ACTIVE;
        col      <= '0;
        row      <= '0;
        row_base <= '0;
        err_out  <= 1'b0;
      end else if (active) begin
        if (vsync_rise) begin
          state          <= SYNC;
          frame_done_out <= 1'b1;
        end
        if (href_fall) begin
          col <= '0;
          if (row != CNT_MAX) row <= row + 11'd1;
          // Row base tracks row*FB_W incrementally; frozen once past the window.
          if (row < ROW_LIM) row_base <= row_base + ROW_STEP;
          if (half) err_out <= 1'b1;
        end else if (pix_vld) begin
          if (col < COL_LIM && row < ROW_LIM && !frozen) begin
            bus.fb_we_out   <= 1'b1;
            bus.fb_addr_out <= row_base + ADDR_W'(col);
            bus.fb_data_out <= pix;
          end
          if (col != CNT_MAX) col <= col + 11'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cam_fb_writer.sv
// Scoreboard bench for cam_fb_writer: stimulus pushes expected writes, a monitor pops and compares.
module tb_cam_fb_writer;
  localparam int W = 240;
  localparam int H = 320;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic freeze = 1'b0;
  logic frame_done, err;

  cam_fb_writer_if #(.ADDR_W(17)) bus ();

  cam_fb_writer #(.FB_W(W), .FB_H(H), .ADDR_W(17)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
`ifdef CAM_FB_FREEZE_EN
    .freeze_in      (freeze),
`endif
    .bus            (bus),
    .frame_done_out (frame_done),
    .err_out        (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [32:0] sb[$];
  int done_cnt = 0;
  int exp_done = 0;
  int last_addr = -1;
  logic done_prev = 1'b0;

  bit m_active = 0;
  bit m_frozen = 0;
  int m_col = 0;
  int m_row = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void exp_pix(input logic [15:0] d);
    if (m_active) begin
      if (!m_frozen && m_col < W && m_row < H)
        sb.push_back({17'(m_row * W + m_col), d});
      m_col++;
    end
  endfunction

  // Byte i even = hi, odd = pixel index, so byte order and per-pixel data are both visible.
  task automatic line(input int nbytes, input logic [7:0] hi, input bit close);
    bus.cam_href_in = 1'b1;
    tick();
    for (int i = 0; i < nbytes; i++) begin
      bus.cam_byte_in     = (i % 2 == 0) ? hi : 8'(i / 2);
      bus.cam_byte_vld_in = 1'b1;
      if (i % 2 == 1) exp_pix({hi, 8'(i / 2)});
      tick();
    end
    bus.cam_byte_vld_in = 1'b0;
    if (close) begin
      tick();
      bus.cam_href_in = 1'b0;
      tick();
      if (m_active) begin
        m_row++;
        m_col = 0;
      end
      tick();
    end
  endtask

  task automatic frame_begin();
    bus.cam_vsync_in = 1'b1;
    tick();
    if (m_active) exp_done++;
    tick();
    bus.cam_vsync_in = 1'b0;
    tick();
    m_active = 1;
    m_frozen = freeze;
    m_col = 0;
    m_row = 0;
    tick();
  endtask

  task automatic frame_end();
    bus.cam_vsync_in = 1'b1;
    tick();
    if (m_active) exp_done++;
    m_active = 0;
    tick();
  endtask

  task automatic drain(input string name);
    repeat (4) tick();
    chk(name, sb.size(), 0);
    chk("frame_done_cnt", done_cnt, exp_done);
  endtask

  // Monitor: compares every write and frame_done pulse against the scoreboard.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (bus.fb_we_out) begin
        last_addr = int'(bus.fb_addr_out);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual_addr=%0d data=%0h required=none", bus.fb_addr_out, bus.fb_data_out);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(bus.fb_addr_out), 32'(e[32:16]));
          chk("wr_data", 32'(bus.fb_data_out), 32'(e[15:0]));
        end
      end
      if (frame_done) begin
        done_cnt++;
        if (done_prev) chk("frame_done_width", 2, 1);
      end
      done_prev = frame_done;
    end
  end

  initial begin
    bus.cam_vsync_in = 1'b0;
    bus.cam_href_in = 1'b0;
    bus.cam_byte_vld_in = 1'b0;
    bus.cam_byte_in = 8'h00;
    repeat (3) tick();
    chk("rst_we", bus.fb_we_out, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // 1: no vsync fall yet, everything ignored
    line(10, 8'h11, 1);
    line(7, 8'h22, 1);
    chk("t1_addr", 32'(bus.fb_addr_out), 0);
    chk("t1_data", 32'(bus.fb_data_out), 0);
    chk("t1_err", err, 0);
    drain("t1_sb_empty");

    // 2: two full lines, then frame end
    frame_begin();
    line(2 * W, 8'hAB, 1);
    line(2 * W, 8'hCD, 1);
    chk("t2_err", err, 0);
    frame_end();
    drain("t2_sb_empty");
    chk("t2_last_addr", last_addr, 479);

    // 3: over-long line clipped at FB_W, next line starts at 240
    frame_begin();
    line(500, 8'h12, 1);
    line(4, 8'h34, 1);
    frame_end();
    drain("t3_sb_empty");
    chk("t3_last_addr", last_addr, 241);

    // 4: half pixel sets err, next line realigned, next frame clears err
    frame_begin();
    line(5, 8'h56, 1);
    chk("t4_err_set", err, 1);
    line(6, 8'h78, 1);
    chk("t4_err_sticky", err, 1);
    frame_begin();
    chk("t4_err_clr", err, 0);
    drain("t4_sb_empty");

    // 5: rows beyond FB_H produce no writes
    for (int r = 0; r < H + 2; r++) begin
      if (r == H - 1) line(2 * W, 8'h9A, 1);
      else line(2, 8'(r), 1);
    end
    frame_end();
    drain("t5_sb_empty");
    chk("t5_last_addr", last_addr, W * H - 1);

    // 6: reset mid-line
    frame_begin();
    line(3, 8'hBC, 1);
    line(20, 8'hDE, 0);
    tick();
    chk("t6_pre_err", err, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_addr", 32'(bus.fb_addr_out), 0);
    chk("t6_rst_data", 32'(bus.fb_data_out), 0);
    chk("t6_rst_err", err, 0);
    m_active = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    bus.cam_href_in = 1'b0;
    tick();
    line(8, 8'h44, 1);
    frame_begin();
    line(4, 8'h66, 1);
    drain("t6_sb_empty");
    chk("t6_last_addr", last_addr, 1);

`ifdef CAM_FB_FREEZE_EN
    // 7: frozen frame writes nothing; mid-frame toggle ignored
    freeze = 1'b1;
    frame_begin();
    line(8, 8'h70, 1);
    freeze = 1'b0;
    line(8, 8'h71, 1);
    frame_end();
    drain("t7_frozen_sb_empty");
    frame_begin();
    freeze = 1'b1;
    line(4, 8'h72, 1);
    frame_end();
    freeze = 1'b0;
    drain("t7_thaw_sb_empty");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
